mem_access_stage: RTL and testbench

//  Pipeline stage directly downstream of the execute stage.
//  - Performs RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) against a ready/valid data-memory port.
//  - Resolves taken branches/jumps into a one-cycle redirect pulse.
//  - Selects the write-back value and registers it for the write-back stage.

---
 rtl/mem_access_stage_pkg.sv | 47 ++++
 rtl/mem_access_stage_if.sv | 24 ++
 rtl/mem_access_stage_load_align_ext.sv | 25 ++
 rtl/mem_access_stage.sv | 150 +++++++++++++++
 tb/tb_mem_access_stage.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage: funct3 encodings,
// FSM state type and the store lane helpers.
package mem_access_stage_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } mem_state_t;

    // Byte strobes for a store; size is funct3[1:0] (byte, half, word).
    function automatic logic [3:0] store_wstrb(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   store_wstrb = 4'b0001 << offset;
            2'b01:   store_wstrb = 4'b0011 << offset;
            default: store_wstrb = 4'hF;
        endcase
    endfunction

    // Store data replicated across every lane the strobes may select.
    function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] rs2);
        case (size)
            2'b00:   store_wdata = {4{rs2[7:0]}};
            2'b01:   store_wdata = {2{rs2[15:0]}};
            default: store_wdata = rs2;
        endcase
    endfunction

    // Halves need an even address, words a 4-byte aligned one.
    function automatic logic misaligned_access(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            2'b00:   misaligned_access = 1'b0;
            2'b01:   misaligned_access = offset[0];
            default: misaligned_access = |offset;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus: the stage is the master, memory the slave.
interface mem_access_stage_if #(
    parameter int XLEN   = 32,
    parameter int STRB_W = XLEN / 8
);
    logic              dmem_req_valid;
    logic              dmem_req_ready;
    logic              dmem_we;
    logic [XLEN-1:0]   dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [STRB_W-1:0] dmem_wstrb;
    logic              dmem_rsp_valid;
    logic [XLEN-1:0]   dmem_rdata;

    modport master (
        output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage_load_align_ext.sv
// Picks the addressed byte/half out of a loaded word and sign/zero extends it.
module load_align_ext
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);
    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    // Extension selected by the load flavour; LW passes the word through.
    always_comb begin
        value = rdata;
        case (funct3)
            F3_LB:   value = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   value = {{16{shifted[15]}}, shifted[15:0]};
            F3_LBU:  value = {24'b0, shifted[7:0]};
            F3_LHU:  value = {16'b0, shifted[15:0]};
            default: value = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: issues loads/stores on the dmem bus, turns taken
// branches/jumps into a redirect pulse and registers the write-back result.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STRB_W = XLEN / 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_last,
    output logic             ready_last,
    input  logic [XLEN-1:0]  ex_result,
    input  logic [XLEN-1:0]  rs2_value,
    input  logic [XLEN-1:0]  rd_value,
    input  logic [2:0]       funct3,
    input  logic [4:0]       rd,
    input  logic             R_wen,
    input  logic [3:0]       csr_wen,
    input  logic             mem_wen,
    input  logic             mem_ren,
    input  logic             jump_flag,
    input  logic             branch_flag,
    input  logic [XLEN-1:0]  branch_pc,
    input  logic [XLEN-1:0]  pc,
    mem_access_stage_if.master dmem,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             misalign_err,
    output logic             valid_next,
    input  logic             ready_next,
    output logic [4:0]       wb_rd,
    output logic             wb_R_wen,
    output logic [3:0]       wb_csr_wen,
    output logic [XLEN-1:0]  wb_value,
    output logic [XLEN-1:0]  pc_out
);
    mem_state_t        state, next_state;
    logic              accept, is_mem, misaligned, mem_go, grant, rsp_done;
    logic [XLEN-1:0]   ex_p1, wdata_p1, pc_p1, load_value;
    logic [STRB_W-1:0] wstrb_p1;
    logic [2:0]        funct3_p1;
    logic [4:0]        rd_p1;
    logic [3:0]        csr_wen_p1;
    logic              R_wen_p1, we_p1;

    assign is_mem     = mem_wen | mem_ren;
    assign misaligned = is_mem & misaligned_access(funct3[1:0], ex_result[1:0]);
    assign mem_go     = is_mem & ~misaligned;
    assign ready_last = (state == IDLE) & (~valid_next | ready_next);
    assign accept     = valid_last & ready_last;
    assign grant      = (state == REQ) & dmem.dmem_req_ready;
    assign rsp_done   = (state == RSP) & dmem.dmem_rsp_valid;

    assign dmem.dmem_addr  = {ex_p1[XLEN-1:2], 2'b00};
    assign dmem.dmem_wdata = wdata_p1;
    assign dmem.dmem_wstrb = wstrb_p1;
    assign dmem.dmem_we    = we_p1;

    load_align_ext u_load_align_ext (
        .rdata  (dmem.dmem_rdata),
        .offset (ex_p1[1:0]),
        .funct3 (funct3_p1),
        .value  (load_value)
    );

    // FSM state register; reset abandons any outstanding request/response.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic and the request strobe.
    always_comb begin
        next_state          = state;
        dmem.dmem_req_valid = 1'b0;
        case (state)
            IDLE: if (accept && mem_go) next_state = REQ;
            REQ: begin
                dmem.dmem_req_valid = 1'b1;
                if (grant) next_state = we_p1 ? IDLE : RSP;
            end
            RSP:  if (dmem.dmem_rsp_valid) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // p1: instruction fields captured on accept, held through REQ/RSP.
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_p1 <= '0; wdata_p1 <= '0; pc_p1 <= '0; wstrb_p1 <= '0;
            funct3_p1 <= '0; rd_p1 <= '0; csr_wen_p1 <= '0;
            R_wen_p1 <= 1'b0; we_p1 <= 1'b0;
        end else if (accept) begin
            ex_p1      <= ex_result;
            wdata_p1   <= store_wdata(funct3[1:0], rs2_value);
            wstrb_p1   <= store_wstrb(funct3[1:0], ex_result[1:0]);
            pc_p1      <= pc;
            funct3_p1  <= funct3;
            rd_p1      <= rd;
            csr_wen_p1 <= csr_wen;
            R_wen_p1   <= R_wen;
            we_p1      <= mem_wen;
        end
    end

    // Redirect and misalignment pulses, one cycle after accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            misalign_err   <= 1'b0;
        end else begin
            redirect_valid <= accept & (jump_flag | (branch_flag & ex_result[0]));
            misalign_err   <= accept & misaligned;
            if (accept) redirect_pc <= branch_pc;
        end
    end

    // p2: write-back register; a completing result wins over a retiring one.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_next <= 1'b0; wb_rd <= '0; wb_R_wen <= 1'b0;
            wb_csr_wen <= '0; wb_value <= '0; pc_out <= '0;
        end else if (accept && !mem_go) begin
            valid_next <= 1'b1;
            wb_rd      <= rd;
            wb_R_wen   <= R_wen & ~misaligned;
            wb_csr_wen <= csr_wen;
            wb_value   <= jump_flag ? rd_value : ex_result;
            pc_out     <= pc;
        end else if (grant && we_p1) begin
            valid_next <= 1'b1;
            wb_rd      <= rd_p1;
            wb_R_wen   <= 1'b0;
            wb_csr_wen <= csr_wen_p1;
            wb_value   <= ex_p1;
            pc_out     <= pc_p1;
        end else if (rsp_done) begin
            valid_next <= 1'b1;
            wb_rd      <= rd_p1;
            wb_R_wen   <= R_wen_p1;
            wb_csr_wen <= csr_wen_p1;
            wb_value   <= load_value;
            pc_out     <= pc_p1;
        end else if (ready_next) begin
            valid_next <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a vector table of single instructions
// with a small memory responder, plus hand sequences for hold and reset.
module tb_mem_access_stage;
    logic        clock, reset;
    logic        valid_last, ready_last;
    logic [31:0] ex_result, rs2_value, rd_value, branch_pc, pc;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        R_wen, mem_wen, mem_ren, jump_flag, branch_flag;
    logic [3:0]  csr_wen;
    logic        redirect_valid, misalign_err, valid_next, ready_next;
    logic [31:0] redirect_pc, wb_value, pc_out;
    logic [4:0]  wb_rd;
    logic        wb_R_wen;
    logic [3:0]  wb_csr_wen;

    mem_access_stage_if dmem_bus ();

    mem_access_stage dut (
        .clock(clock), .reset(reset), .valid_last(valid_last), .ready_last(ready_last),
        .ex_result(ex_result), .rs2_value(rs2_value), .rd_value(rd_value), .funct3(funct3),
        .rd(rd), .R_wen(R_wen), .csr_wen(csr_wen), .mem_wen(mem_wen), .mem_ren(mem_ren),
        .jump_flag(jump_flag), .branch_flag(branch_flag), .branch_pc(branch_pc), .pc(pc),
        .dmem(dmem_bus), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .misalign_err(misalign_err), .valid_next(valid_next), .ready_next(ready_next),
        .wb_rd(wb_rd), .wb_R_wen(wb_R_wen), .wb_csr_wen(wb_csr_wen), .wb_value(wb_value),
        .pc_out(pc_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        string       nm;
        logic [2:0]  f3;
        logic [31:0] ex, rs2, rdv, bpc, rdata;
        logic        ren, wen, jmp, br, rwen;
        int          gdel;
        logic        chk_val;
        logic [31:0] exp_val;
        logic        exp_rwen;
        int          exp_lat, exp_req;
        logic [31:0] exp_addr, exp_wdata;
        logic [3:0]  exp_wstrb;
        int          exp_redir, exp_mis;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        v;
        logic        got, rsp_now, cap_we;
        int          lat, req_seen, redir_n, mis_n, busy_rl, req_wait;
        logic [31:0] cap_val, cap_rpc, cap_addr, cap_wdata, cap_pc;
        logic [3:0]  cap_wstrb, cap_csr;
        logic [4:0]  cap_rd;
        logic        cap_rwen;

        //         name        f3      ex            rs2           rdv         bpc          rdata         ren wen jmp br rwen gdel chk exp_val      exp_rwen lat req addr         wdata         wstrb  redir mis
        vecs[0]  = '{"lw_late",  3'b010, 32'h100,  32'h0,        32'h0,      32'h0,       32'hDEADBEEF, 1, 0, 0, 0, 1, 2, 1, 32'hDEADBEEF, 1, 4, 1, 32'h100, 32'h0,        4'h0,  0, 0};
        vecs[1]  = '{"lb_neg",   3'b000, 32'h103,  32'h0,        32'h0,      32'h0,       32'h80AABBCC, 1, 0, 0, 0, 1, 0, 1, 32'hFFFFFF80, 1, 2, 1, 32'h100, 32'h0,        4'h0,  0, 0};
        vecs[2]  = '{"lhu_hi",   3'b101, 32'h102,  32'h0,        32'h0,      32'h0,       32'h80AABBCC, 1, 0, 0, 0, 1, 0, 1, 32'h000080AA, 1, 2, 1, 32'h100, 32'h0,        4'h0,  0, 0};
        vecs[3]  = '{"lh_hi",    3'b001, 32'h102,  32'h0,        32'h0,      32'h0,       32'h80AABBCC, 1, 0, 0, 0, 1, 0, 1, 32'hFFFF80AA, 1, 2, 1, 32'h100, 32'h0,        4'h0,  0, 0};
        vecs[4]  = '{"lbu_b1",   3'b100, 32'h101,  32'h0,        32'h0,      32'h0,       32'h80AABBCC, 1, 0, 0, 0, 1, 0, 1, 32'h000000BB, 1, 2, 1, 32'h100, 32'h0,        4'h0,  0, 0};
        vecs[5]  = '{"sb_b1",    3'b000, 32'h201,  32'h12345678, 32'h0,      32'h0,       32'h0,        0, 1, 0, 0, 1, 0, 0, 32'h0,        0, 1, 1, 32'h200, 32'h78787878, 4'h2,  0, 0};
        vecs[6]  = '{"sh_hi",    3'b001, 32'h206,  32'h0000ABCD, 32'h0,      32'h0,       32'h0,        0, 1, 0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 32'h204, 32'hABCDABCD, 4'hC,  0, 0};
        vecs[7]  = '{"sw_late",  3'b010, 32'h300,  32'hCAFEF00D, 32'h0,      32'h0,       32'h0,        0, 1, 0, 0, 0, 1, 0, 32'h0,        0, 2, 1, 32'h300, 32'hCAFEF00D, 4'hF,  0, 0};
        vecs[8]  = '{"beq_tk",   3'b000, 32'h1,    32'h0,        32'h0,      32'h400,     32'h0,        0, 0, 0, 1, 0, 0, 1, 32'h1,        0, 0, 0, 32'h0,   32'h0,        4'h0,  1, 0};
        vecs[9]  = '{"beq_nt",   3'b000, 32'h0,    32'h0,        32'h0,      32'h500,     32'h0,        0, 0, 0, 1, 0, 0, 1, 32'h0,        0, 0, 0, 32'h0,   32'h0,        4'h0,  0, 0};
        vecs[10] = '{"jal",      3'b000, 32'h2000, 32'h0,        32'h1004,   32'h800,     32'h0,        0, 0, 1, 0, 1, 0, 1, 32'h1004,     1, 0, 0, 32'h0,   32'h0,        4'h0,  1, 0};
        vecs[11] = '{"lw_mis",   3'b010, 32'h102,  32'h0,        32'h0,      32'h0,       32'h0,        1, 0, 0, 0, 1, 0, 1, 32'h102,      0, 0, 0, 32'h0,   32'h0,        4'h0,  0, 1};
        vecs[12] = '{"lh_mis",   3'b001, 32'h101,  32'h0,        32'h0,      32'h0,       32'h0,        1, 0, 0, 0, 1, 0, 1, 32'h101,      0, 0, 0, 32'h0,   32'h0,        4'h0,  0, 1};
        vecs[13] = '{"sh_mis",   3'b001, 32'h203,  32'h1111,     32'h0,      32'h0,       32'h0,        0, 1, 0, 0, 0, 0, 1, 32'h203,      0, 0, 0, 32'h0,   32'h0,        4'h0,  0, 1};
        vecs[14] = '{"alu",      3'b000, 32'h55,   32'h0,        32'h0,      32'h0,       32'h0,        0, 0, 0, 0, 1, 0, 1, 32'h55,       1, 0, 0, 32'h0,   32'h0,        4'h0,  0, 0};
        vecs[15] = '{"lw_fast",  3'b010, 32'h104,  32'h0,        32'h0,      32'h0,       32'h01234567, 1, 0, 0, 0, 1, 0, 1, 32'h01234567, 1, 2, 1, 32'h104, 32'h0,        4'h0,  0, 0};

        reset = 1'b1; valid_last = 1'b0; ready_next = 1'b1;
        ex_result = '0; rs2_value = '0; rd_value = '0; branch_pc = '0; pc = '0;
        funct3 = '0; rd = '0; R_wen = 1'b0; csr_wen = '0;
        mem_wen = 1'b0; mem_ren = 1'b0; jump_flag = 1'b0; branch_flag = 1'b0;
        dmem_bus.dmem_req_ready = 1'b0; dmem_bus.dmem_rsp_valid = 1'b0; dmem_bus.dmem_rdata = '0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_valid_next", 32'(valid_next), 0);
        chk("reset_redirect", 32'(redirect_valid), 0);
        chk("reset_misalign", 32'(misalign_err), 0);
        chk("reset_req_valid", 32'(dmem_bus.dmem_req_valid), 0);
        chk("reset_wb_value", wb_value, 0);
        chk("reset_wb_rwen", 32'(wb_R_wen), 0);
        chk("reset_pc_out", pc_out, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            funct3 = v.f3; ex_result = v.ex; rs2_value = v.rs2; rd_value = v.rdv;
            branch_pc = v.bpc; mem_ren = v.ren; mem_wen = v.wen; jump_flag = v.jmp;
            branch_flag = v.br; R_wen = v.rwen;
            rd = 5'(i + 1); pc = 32'h1000 + 32'(i * 4); csr_wen = 4'(i);
            valid_last = 1'b1;
            got = 1'b0; rsp_now = 1'b0; lat = -1; req_seen = 0; redir_n = 0; mis_n = 0;
            busy_rl = 0; req_wait = 0; cap_we = 1'b0;
            cap_val = '0; cap_rpc = '0; cap_addr = '0; cap_wdata = '0; cap_wstrb = '0;
            cap_pc = '0; cap_csr = '0; cap_rd = '0; cap_rwen = 1'b0;
            for (int c = 0; c < 24; c++) begin
                @(posedge clock); #1;
                valid_last = 1'b0;
                dmem_bus.dmem_req_ready = 1'b0;
                dmem_bus.dmem_rsp_valid = 1'b0;
                if (rsp_now) begin
                    dmem_bus.dmem_rsp_valid = 1'b1;
                    dmem_bus.dmem_rdata = v.rdata;
                    rsp_now = 1'b0;
                end
                if (redirect_valid) begin redir_n++; cap_rpc = redirect_pc; end
                if (misalign_err) mis_n++;
                if (!got && valid_next) begin
                    got = 1'b1; lat = c;
                    cap_val = wb_value; cap_rwen = wb_R_wen; cap_rd = wb_rd;
                    cap_pc = pc_out; cap_csr = wb_csr_wen;
                end else if (!got && ready_last) begin
                    busy_rl++;
                end
                if (dmem_bus.dmem_req_valid) begin
                    req_seen = 1;
                    cap_addr = dmem_bus.dmem_addr; cap_wdata = dmem_bus.dmem_wdata;
                    cap_wstrb = dmem_bus.dmem_wstrb; cap_we = dmem_bus.dmem_we;
                    if (req_wait >= v.gdel) begin
                        dmem_bus.dmem_req_ready = 1'b1;
                        if (!dmem_bus.dmem_we) rsp_now = 1'b1;
                    end
                    req_wait++;
                end
                if (got && c >= lat + 2) break;
            end
            chk({v.nm, "_completed"}, 32'(got), 1);
            if (v.chk_val) chk({v.nm, "_wb_value"}, cap_val, v.exp_val);
            chk({v.nm, "_wb_rwen"}, 32'(cap_rwen), 32'(v.exp_rwen));
            chk({v.nm, "_wb_rd"}, 32'(cap_rd), 32'(i + 1));
            chk({v.nm, "_pc_out"}, cap_pc, 32'h1000 + 32'(i * 4));
            chk({v.nm, "_csr_wen"}, 32'(cap_csr), 32'(i % 16));
            chk({v.nm, "_latency"}, 32'(lat), 32'(v.exp_lat));
            chk({v.nm, "_req_seen"}, 32'(req_seen), 32'(v.exp_req));
            chk({v.nm, "_ready_last_busy"}, 32'(busy_rl), 0);
            chk({v.nm, "_redirects"}, 32'(redir_n), 32'(v.exp_redir));
            chk({v.nm, "_misalign"}, 32'(mis_n), 32'(v.exp_mis));
            if (v.exp_redir != 0) chk({v.nm, "_redirect_pc"}, cap_rpc, v.bpc);
            if (v.exp_req != 0) begin
                chk({v.nm, "_addr"}, cap_addr, v.exp_addr);
                chk({v.nm, "_we"}, 32'(cap_we), 32'(v.wen));
                if (v.wen) begin
                    chk({v.nm, "_wstrb"}, 32'(cap_wstrb), 32'(v.exp_wstrb));
                    chk({v.nm, "_wdata"}, cap_wdata, v.exp_wdata);
                end
            end
            mem_ren = 1'b0; mem_wen = 1'b0; jump_flag = 1'b0; branch_flag = 1'b0;
        end

        // Output hold: write-back stalled for four cycles behind an ALU result.
        ready_next = 1'b0;
        ex_result = 32'h55; rd = 5'd7; funct3 = 3'b000; R_wen = 1'b1; rd_value = '0;
        csr_wen = '0; pc = 32'h3000; valid_last = 1'b1;
        @(posedge clock); #1;
        ex_result = 32'h66; rd = 5'd8; pc = 32'h3004;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin @(posedge clock); #1; end
            chk("hold_valid_next", 32'(valid_next), 1);
            chk("hold_wb_value", wb_value, 32'h55);
            chk("hold_ready_last", 32'(ready_last), 0);
        end
        ready_next = 1'b1;
        @(posedge clock); #1;
        valid_last = 1'b0;
        chk("backtoback_valid_next", 32'(valid_next), 1);
        chk("backtoback_wb_value", wb_value, 32'h66);
        chk("backtoback_wb_rd", 32'(wb_rd), 8);
        @(posedge clock); #1;
        chk("drain_valid_next", 32'(valid_next), 0);

        // Reset while a load waits in RSP, then a stray response afterwards.
        ex_result = 32'h100; funct3 = 3'b010; mem_ren = 1'b1; R_wen = 1'b1; rd = 5'd9;
        valid_last = 1'b1;
        @(posedge clock); #1;
        valid_last = 1'b0; mem_ren = 1'b0;
        chk("rst_seq_req_valid", 32'(dmem_bus.dmem_req_valid), 1);
        dmem_bus.dmem_req_ready = 1'b1;
        @(posedge clock); #1;
        dmem_bus.dmem_req_ready = 1'b0;
        chk("rst_seq_in_rsp_req", 32'(dmem_bus.dmem_req_valid), 0);
        chk("rst_seq_in_rsp_ready_last", 32'(ready_last), 0);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("rst_mid_valid_next", 32'(valid_next), 0);
        chk("rst_mid_wb_value", wb_value, 0);
        chk("rst_mid_wb_rd", 32'(wb_rd), 0);
        chk("rst_mid_pc_out", pc_out, 0);
        chk("rst_mid_req_valid", 32'(dmem_bus.dmem_req_valid), 0);
        chk("rst_mid_addr", dmem_bus.dmem_addr, 0);
        chk("rst_mid_ready_last", 32'(ready_last), 1);
        dmem_bus.dmem_rsp_valid = 1'b1; dmem_bus.dmem_rdata = 32'h11111111;
        @(posedge clock); #1;
        dmem_bus.dmem_rsp_valid = 1'b0;
        chk("late_rsp_valid_next", 32'(valid_next), 0);
        chk("late_rsp_wb_value", wb_value, 0);
        @(posedge clock); #1;
        chk("late_rsp_idle_ready", 32'(ready_last), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
